// File: rtl/stream_row_capture.sv
// -----------------------------------------------------------------------------
// stream_row_capture
//
// Captures an AXI-Stream video frame of packed 24-bit RGB pixels (four pixels
// in every three 32-bit words) into a grid of 1-bit cells, one BRAM row per
// video line. A cell is alive when any colour channel of its pixel is
// nonzero. Pixel x of a line lands in row_wr_data bit X_SIZE-1-x. The block
// flags short lines, long lines and unexpected start-of-frame markers.
//
// Ports
//   in_stream_aclk   : clock, all logic on the rising edge
//   periph_reset     : synchronous active-high reset
//   in_stream_tdata  : packed pixel data (three words hold four pixels)
//   in_stream_tvalid : word valid
//   in_stream_tlast  : end of line marker
//   in_stream_tuser  : start of frame marker
//   in_stream_tkeep  : byte enables, not used
//   in_stream_tready : word accepted when tvalid && tready
//   row_wr_addr      : row address of the pending write
//   row_wr_data      : one grid row of cells
//   row_wr_en        : row write request, held until row_wr_ready
//   row_wr_ready     : row write acknowledge
//   frame_done       : one-cycle pulse after the last row of a frame is written
//   err_short        : one-cycle pulse, line ended early (row discarded)
//   err_long         : one-cycle pulse, line ran past its length (row discarded)
//   err_sof          : one-cycle pulse, start of frame arrived mid-frame
// -----------------------------------------------------------------------------
module stream_row_capture #(
  parameter int X_SIZE = 1280,
  parameter int Y_SIZE = 720
) (
  input  logic                      in_stream_aclk,
  input  logic                      periph_reset,
  input  logic [31:0]               in_stream_tdata,
  input  logic                      in_stream_tvalid,
  input  logic                      in_stream_tlast,
  input  logic                      in_stream_tuser,
  input  logic [3:0]                in_stream_tkeep,
  output logic                      in_stream_tready,
  output logic [$clog2(Y_SIZE)-1:0] row_wr_addr,
  output logic [X_SIZE-1:0]         row_wr_data,
  output logic                      row_wr_en,
  input  logic                      row_wr_ready,
  output logic                      frame_done,
  output logic                      err_short,
  output logic                      err_long,
  output logic                      err_sof
);

  localparam int WPL = X_SIZE * 3 / 4;          // words per line
  localparam int RW  = $clog2(Y_SIZE);
  localparam int XW  = $clog2(X_SIZE);
  localparam int CW  = $clog2(WPL) + 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(WPL - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(Y_SIZE - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(X_SIZE - 1);

  typedef enum logic [1:0] {
    S_WAIT_SOF = 2'd0,
    S_RECV     = 2'd1,
    S_WRITE    = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [CW-1:0]     r_word_cnt;   // index of the next expected word in the line
  logic [RW-1:0]     r_row;
  logic [1:0]        r_phase;      // position of the next word inside its 3-word group
  logic [XW-1:0]     r_xbase;      // first pixel index of the current 4-pixel group
  logic [15:0]       r_hold;       // pixel bytes carried over to the next word
  logic [X_SIZE-1:0] r_row_data;
  logic              r_wr_en;
  logic              r_frame_done;
  logic              r_err_short;
  logic              r_err_long;
  logic              r_err_sof;

  logic              w_tready;
  logic              w_acc;
  logic              w_sof_word;
  logic              w_sof_err;
  logic              w_short;
  logic              w_long;
  logic              w_wr_done;
  logic              w_pix_word;
  logic              w_last_word;
  logic [CW-1:0]     w_idx;
  logic [1:0]        w_ph;
  logic [XW-1:0]     w_xb;
  logic [XW-1:0]     w_bit_idx;
  logic [23:0]       w_pix_a;
  logic [23:0]       w_pix_b;
  logic              w_unused_keep;

  function automatic logic pixel_alive(input logic [23:0] pix);
    return |pix;
  endfunction

  assign w_unused_keep = ^in_stream_tkeep;

  assign w_tready   = (r_state != S_WRITE) && !periph_reset;
  assign w_acc      = in_stream_tvalid && w_tready;
  // Any accepted tuser word starts a fresh frame at word 0 of row 0.
  assign w_sof_word = w_acc && in_stream_tuser;

  // Next-state logic and per-word line checks.
  always_comb begin
    w_next      = r_state;
    w_sof_err   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_wr_done   = 1'b0;
    w_pix_word  = 1'b0;
    w_idx       = w_sof_word ? {CW{1'b0}} : r_word_cnt;
    w_last_word = (w_idx == LAST_IDX);
    case (r_state)
      S_WAIT_SOF: begin
        if (w_sof_word) begin
          w_pix_word = 1'b1;
        end else begin
          w_next = S_WAIT_SOF;
        end
      end
      S_RECV: begin
        if (w_acc) begin
          w_pix_word = 1'b1;
          if (w_sof_word && ((r_row != RW'(0)) || (r_word_cnt != CW'(0)))) begin
            w_sof_err = 1'b1;
          end else begin
            w_sof_err = 1'b0;
          end
        end else begin
          w_next = S_RECV;
        end
      end
      S_DROP: begin
        if (w_sof_word) begin
          w_pix_word = 1'b1;
          w_sof_err  = 1'b1;
        end else if (w_acc && in_stream_tlast) begin
          w_next = S_WAIT_SOF;
        end else begin
          w_next = S_DROP;
        end
      end
      S_WRITE: begin
        if (row_wr_ready) begin
          w_wr_done = 1'b1;
          w_next    = (r_row == LAST_ROW) ? S_WAIT_SOF : S_RECV;
        end else begin
          w_next = S_WRITE;
        end
      end
      default: begin
        w_next = S_WAIT_SOF;
      end
    endcase
    // Line-length checks; an err_sof on the same word masks the other errors.
    if (w_pix_word) begin
      if (in_stream_tlast && !w_last_word) begin
        w_next  = S_WAIT_SOF;
        w_short = !w_sof_err;
      end else if (w_last_word && in_stream_tlast) begin
        w_next = S_WRITE;
      end else if (w_last_word) begin
        w_next = S_DROP;
        w_long = !w_sof_err;
      end else begin
        w_next = S_RECV;
      end
    end else begin
      w_short = 1'b0;
    end
  end

  // Selects the pixel(s) completed by the current word and their cell index.
  always_comb begin
    w_ph    = w_sof_word ? 2'd0 : r_phase;
    w_xb    = w_sof_word ? {XW{1'b0}} : r_xbase;
    w_pix_b = in_stream_tdata[31:8];
    case (w_ph)
      2'd0:    w_pix_a = in_stream_tdata[23:0];
      2'd1:    w_pix_a = {in_stream_tdata[15:0], r_hold[7:0]};
      2'd2:    w_pix_a = {in_stream_tdata[7:0], r_hold};
      default: w_pix_a = 24'd0;
    endcase
    w_bit_idx = X_MAX - w_xb - XW'(w_ph);
  end

  // State register.
  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      r_state <= S_WAIT_SOF;
    end else begin
      r_state <= w_next;
    end
  end

  // Row assembly, row counter, write request and pulse outputs.
  always_ff @(posedge in_stream_aclk) begin
    if (periph_reset) begin
      r_word_cnt   <= {CW{1'b0}};
      r_row        <= {RW{1'b0}};
      r_phase      <= 2'd0;
      r_xbase      <= {XW{1'b0}};
      r_hold       <= 16'd0;
      r_row_data   <= {X_SIZE{1'b0}};
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_err_short  <= 1'b0;
      r_err_long   <= 1'b0;
      r_err_sof    <= 1'b0;
    end else begin
      r_wr_en      <= (w_next == S_WRITE);
      r_frame_done <= w_wr_done && (r_row == LAST_ROW);
      r_err_short  <= w_short;
      r_err_long   <= w_long;
      r_err_sof    <= w_sof_err;
      if (w_pix_word) begin
        r_word_cnt <= w_idx + CW'(1);
        if (w_sof_word) begin
          r_row <= {RW{1'b0}};
        end
        case (w_ph)
          2'd0: begin
            r_row_data[w_bit_idx] <= pixel_alive(w_pix_a);
            r_hold[7:0]           <= in_stream_tdata[31:24];
            r_phase               <= 2'd1;
            r_xbase               <= w_xb;
          end
          2'd1: begin
            r_row_data[w_bit_idx] <= pixel_alive(w_pix_a);
            r_hold                <= in_stream_tdata[31:16];
            r_phase               <= 2'd2;
            r_xbase               <= w_xb;
          end
          2'd2: begin
            r_row_data[w_bit_idx]          <= pixel_alive(w_pix_a);
            r_row_data[w_bit_idx - XW'(1)] <= pixel_alive(w_pix_b);
            r_phase                        <= 2'd0;
            r_xbase                        <= w_xb + XW'(4);
          end
          default: begin
            r_phase <= 2'd0;
            r_xbase <= {XW{1'b0}};
          end
        endcase
      end else if (w_wr_done) begin
        r_row      <= (r_row == LAST_ROW) ? {RW{1'b0}} : r_row + RW'(1);
        r_word_cnt <= {CW{1'b0}};
        r_phase    <= 2'd0;
        r_xbase    <= {XW{1'b0}};
      end
    end
  end

  assign in_stream_tready = w_tready;
  assign row_wr_addr      = r_row;
  assign row_wr_data      = r_row_data;
  assign row_wr_en        = r_wr_en;
  assign frame_done       = r_frame_done;
  assign err_short        = r_err_short;
  assign err_long         = r_err_long;
  assign err_sof          = r_err_sof;

endmodule

// File: doc/stream_row_capture.md
STREAM_ROW_CAPTURE -- requirements
Module: stream_row_capture

Interface
REQ-001 SHALL have parameter X_SIZE, default 1280, meaning pixels per line (a multiple of 4).
REQ-002 SHALL have parameter Y_SIZE, default 720, meaning lines per frame.
REQ-003 SHALL have port in_stream_aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port periph_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_stream_tdata, input, 32 bits: packed 24-bit RGB pixel data.
REQ-006 SHALL have ports in_stream_tvalid (input, 1), in_stream_tlast (input, 1, end of line), in_stream_tuser (input, 1, start of frame) and in_stream_tkeep (input, 4, ignored).
REQ-007 SHALL have port in_stream_tready, output, 1 bit.
REQ-008 SHALL have port row_wr_addr, output, clog2(Y_SIZE) bits: BRAM row address.
REQ-009 SHALL have port row_wr_data, output, X_SIZE bits: one grid row of 1-bit cells.
REQ-010 SHALL have ports row_wr_en (output, 1) and row_wr_ready (input, 1): the row-write handshake.
REQ-011 SHALL have ports frame_done, err_short, err_long and err_sof (all outputs, 1 bit): single-cycle pulses.

Function
REQ-012 SHALL unpack 4 pixels from every 3 accepted words, with pixel p = {r,g,b} and r in bits 23:16:
- w0 = {p1[7:0], p0}
- w1 = {p2[15:0], p1[23:8]}
- w2 = {p3, p2[23:16]}
REQ-013 SHALL count a line as X_SIZE*3/4 words (960 at default).
REQ-014 SHALL treat a cell as alive when any of r, g, b is nonzero, and write pixel x to row_wr_data bit X_SIZE-1-x.
REQ-015 SHALL accept a word only on a cycle with tvalid && tready.
REQ-016 SHALL drive tready = 1 in WAIT_SOF, RECV and DROP, and tready = 0 in WRITE and while periph_reset is high.
REQ-017 SHALL implement states WAIT_SOF, RECV, WRITE and DROP.
REQ-018 In WAIT_SOF, SHALL discard words without tuser; a word with tuser SHALL be taken as word 0 of row 0, with a transition to RECV.
REQ-019 In RECV, when the accepted word is the last word of the line and tlast=1, SHALL go to WRITE on the next cycle.
REQ-020 In WRITE, SHALL assert row_wr_en with stable row_wr_addr and row_wr_data until a cycle with row_wr_ready=1.
REQ-021 On write completion, SHALL increment the row; if the completed row is Y_SIZE-1, SHALL pulse frame_done in the following cycle and go to WAIT_SOF, otherwise SHALL go to RECV.
REQ-022 Row write latency SHALL be: row_wr_en high in the cycle after the last word of the line is accepted.
REQ-023 Short line (tlast on an earlier word): SHALL pulse err_short, discard the partial row without writing it, and go to WAIT_SOF.
REQ-024 Long line (last word of the line accepted with tlast=0): SHALL pulse err_long, discard the row, and go to DROP.
REQ-025 DROP SHALL discard words until a word with tlast is accepted, then go to WAIT_SOF.
REQ-026 tuser on a word in RECV other than word 0 of row 0: SHALL pulse err_sof, discard the partial row, and restart with that word as word 0 of row 0 (state stays RECV).
REQ-027 Words with tuser that arrive in DROP SHALL restart the frame as in REQ-026.
REQ-028 A line of one pixel group (X_SIZE=4, 3 words) SHALL follow the same rules.
REQ-029 Error and frame_done pulses SHALL be exactly one cycle long, and simultaneous error conditions SHALL raise only the first-listed: err_sof, then err_short, then err_long.

Reset
REQ-030 While periph_reset=1, SHALL hold state WAIT_SOF, word count 0, row 0, row_wr_en=0, tready=0, all pulse outputs 0 and row_wr_data all zeros.
REQ-031 Reset asserted mid-row or during WRITE SHALL abandon the row with no row_wr_en in the cycle after reset is asserted.
REQ-032 In the first cycle after reset deasserts, SHALL drive tready=1 and state WAIT_SOF.

Verification
REQ-033 Full frame of 720x960 words, pixel x alive iff x%2==0, tuser on the first word, tlast on every 960th word, row_wr_ready=1 -> 720 writes with addresses 0..719, data bits 1279,1277,... = 1 and other bits 0, frame_done pulsed once.
REQ-034 Hold row_wr_ready=0 for 5 cycles at row 3 -> row_wr_en, address 3 and data stable for 6 cycles, tready=0 for all of them, no words lost.
REQ-035 tlast on word 500 of row 2 -> err_short pulsed, no write for row 2, next tuser frame captured from row 0.
REQ-036 Missing tlast on word 959 of row 0, tlast on word 1000 -> err_long pulsed, no write for row 0, words dropped through word 1000, state WAIT_SOF.
REQ-037 tuser on row 5 word 10 -> err_sof pulsed, that word becomes word 0 of row 0, next write address 0.
REQ-038 periph_reset high for 1 cycle during WRITE of row 7 -> row_wr_en low the next cycle, words without tuser discarded until a tuser word arrives.
